// File: rtl/fifo_pkg.sv
// Shared types and defaults for the synchronous / asynchronous FIFO family.
package fifo_pkg;

    localparam int DSIZE_DEF = 8;
    localparam int ASIZE_DEF = 4;

    // Registered occupancy flags, grouped so a monitor can compare them as one unit.
    typedef struct packed {
        logic wfull;
        logic rempty;
        logic almost_full;
        logic almost_empty;
    } fifo_status_t;

    function automatic int fifo_depth(input int asize);
        return 1 << asize;
    endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// DEPTH x DSIZE flop array: synchronous write port, asynchronous read port.
module fifo_mem_dp
    import fifo_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int ASIZE = ASIZE_DEF
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [ASIZE-1:0] waddr_i,
    input  logic [DSIZE-1:0] wdata_i,
    input  logic [ASIZE-1:0] raddr_i,
    output logic [DSIZE-1:0] rdata_o
);

    localparam int DEPTH = fifo_depth(ASIZE);

    logic [DSIZE-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-full/empty thresholds, occupancy
// count, optional first-word-fall-through and sticky overflow/underflow flags.
module sync_fifo_prog
    import fifo_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int ASIZE = ASIZE_DEF,
    parameter int FWFT  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DSIZE-1:0] wdata_i,
    input  logic             winc_i,
    input  logic             rinc_i,
    input  logic [ASIZE:0]   af_thresh_i,
    input  logic [ASIZE:0]   ae_thresh_i,
    input  logic             clr_err_i,
    output logic [DSIZE-1:0] rdata_o,
    output logic             wfull_o,
    output logic             rempty_o,
    output logic             almost_full_o,
    output logic             almost_empty_o,
    output logic [ASIZE:0]   count_o,
    output logic             overflow_o,
    output logic             underflow_o
);

    localparam int DEPTH = fifo_depth(ASIZE);

    typedef logic [ASIZE:0] fifo_ptr_t;
    localparam fifo_ptr_t DEPTH_P = fifo_ptr_t'(DEPTH);
    localparam fifo_ptr_t ONE_P   = fifo_ptr_t'(1);
    localparam fifo_status_t STATUS_RST = '{wfull: 1'b0, rempty: 1'b1,
                                            almost_full: 1'b0, almost_empty: 1'b1};

    fifo_ptr_t    wptr_q, wptr_d;
    fifo_ptr_t    rptr_q, rptr_d;
    fifo_ptr_t    count_q, count_d;
    fifo_status_t status_q, status_d;
    logic         overflow_q, overflow_d;
    logic         underflow_q, underflow_d;
    logic         wr_acc, rd_acc;
    logic [DSIZE-1:0] mem_rdata;

    // Accept decisions use only the registered flags, never the incoming request.
    assign wr_acc = winc_i && !status_q.wfull;
    assign rd_acc = rinc_i && !status_q.rempty;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (wr_acc) wptr_d = wptr_q + ONE_P;
        if (rd_acc) rptr_d = rptr_q + ONE_P;
        if (wr_acc && !rd_acc)      count_d = count_q + ONE_P;
        else if (!wr_acc && rd_acc) count_d = count_q - ONE_P;

        status_d.wfull        = (count_d == DEPTH_P);
        status_d.rempty       = (count_d == '0);
        status_d.almost_full  = (count_d >= af_thresh_i);
        status_d.almost_empty = (count_d <= ae_thresh_i);

        // Set wins over a coincident clear.
        overflow_d  = (winc_i && status_q.wfull)  || (overflow_q  && !clr_err_i);
        underflow_d = (rinc_i && status_q.rempty) || (underflow_q && !clr_err_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            status_q    <= STATUS_RST;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            status_q    <= status_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_mem_dp #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_acc),
        .waddr_i (wptr_q[ASIZE-1:0]),
        .wdata_i (wdata_i),
        .raddr_i (rptr_q[ASIZE-1:0]),
        .rdata_o (mem_rdata)
    );

    if (FWFT != 0) begin : g_fwft
        // Memory is not reset, so mask the head word while empty to give a clean 0.
        assign rdata_o = status_q.rempty ? '0 : mem_rdata;
    end else begin : g_std
        logic [DSIZE-1:0] rdata_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)      rdata_q <= '0;
            else if (rd_acc) rdata_q <= mem_rdata;
        end
        assign rdata_o = rdata_q;
    end

    assign wfull_o        = status_q.wfull;
    assign rempty_o       = status_q.rempty;
    assign almost_full_o  = status_q.almost_full;
    assign almost_empty_o = status_q.almost_empty;
    assign count_o        = count_q;
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Scoreboard bench: one standard-read and one FWFT instance share stimulus and
// are compared against a queue-based model of the FIFO contents.
module tb_sync_fifo_prog;
    import fifo_pkg::*;

    localparam int DSIZE = 8;
    localparam int ASIZE = 4;
    localparam int DEPTH = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [DSIZE-1:0] wdata = '0;
    logic             winc = 1'b0, rinc = 1'b0, clr_err = 1'b0;
    logic [ASIZE:0]   af_th = 5'd14, ae_th = 5'd2;

    logic [DSIZE-1:0] rdata [2];
    logic [ASIZE:0]   cnt   [2];
    logic             wfull [2], rempty [2], afull [2], aempty [2], ovf [2], udf [2];

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        sync_fifo_prog #(.DSIZE(DSIZE), .ASIZE(ASIZE), .FWFT(g)) u_dut (
            .clk            (clk),
            .rst_n          (rst_n),
            .wdata_i        (wdata),
            .winc_i         (winc),
            .rinc_i         (rinc),
            .af_thresh_i    (af_th),
            .ae_thresh_i    (ae_th),
            .clr_err_i      (clr_err),
            .rdata_o        (rdata[g]),
            .wfull_o        (wfull[g]),
            .rempty_o       (rempty[g]),
            .almost_full_o  (afull[g]),
            .almost_empty_o (aempty[g]),
            .count_o        (cnt[g]),
            .overflow_o     (ovf[g]),
            .underflow_o    (udf[g])
        );
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: FIFO contents as a queue, flags derived from its size.
    logic [DSIZE-1:0] mq [$];
    logic [DSIZE-1:0] exp_q [$];
    bit m_ovf = 0, m_udf = 0, m_af = 0, m_ae = 1;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mq.delete();
            exp_q.delete();
            m_ovf = 0; m_udf = 0; m_af = 0; m_ae = 1;
        end else begin
            int  n;
            bit  wa, ra;
            n  = mq.size();
            wa = winc && (n < DEPTH);
            ra = rinc && (n > 0);
            m_ovf = (winc && n == DEPTH) || (m_ovf && !clr_err);
            m_udf = (rinc && n == 0)     || (m_udf && !clr_err);
            if (ra) exp_q.push_back(mq.pop_front());
            if (wa) mq.push_back(wdata);
            m_af = (mq.size() >= int'(af_th));
            m_ae = (mq.size() <= int'(ae_th));
        end
    end

    // Monitor: pops one expected word per accepted read, checks state every cycle.
    logic [DSIZE-1:0] last0 = '0;
    initial forever begin
        @(negedge clk);
        if (!rst_n) last0 = '0;
        if (exp_q.size() > 0) begin
            last0 = exp_q.pop_front();
            chk("rdata_std", rdata[0], last0);
        end else begin
            chk("rdata_hold", rdata[0], last0);
        end
        if (mq.size() > 0) chk("rdata_fwft", rdata[1], mq[0]);
        for (int d = 0; d < 2; d++) begin
            chk("count", cnt[d], mq.size());
            chk("wfull", wfull[d], mq.size() == DEPTH);
            chk("rempty", rempty[d], mq.size() == 0);
            chk("almost_full", afull[d], m_af);
            chk("almost_empty", aempty[d], m_ae);
            chk("overflow", ovf[d], m_ovf);
            chk("underflow", udf[d], m_udf);
        end
    end

    task automatic step(input bit w, input bit r, input logic [DSIZE-1:0] d, input bit c);
        winc = w; rinc = r; wdata = d; clr_err = c;
        @(negedge clk);
    endtask

    initial begin
        logic [DSIZE-1:0] dv;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // 1: three writes then three reads
        step(1, 0, 8'h11, 0); step(1, 0, 8'h22, 0); step(1, 0, 8'h33, 0);
        chk("t1_count", cnt[0], 3);
        for (int i = 0; i < 3; i++) step(0, 1, 8'h00, 0);
        step(0, 0, 8'h00, 0);
        chk("t1_rdata_last", rdata[0], 8'h33);

        // 2: fill, overflow attempt, drain
        for (int i = 0; i < 16; i++) step(1, 0, DSIZE'(i), 0);
        chk("t2_wfull", wfull[0], 1);
        step(1, 0, 8'hAA, 0);
        chk("t2_overflow", ovf[0], 1);
        for (int i = 0; i < 16; i++) step(0, 1, 8'h00, 0);
        step(0, 0, 8'h00, 1);
        chk("t2_ovf_clr", ovf[0], 0);

        // 3: hold at 8 with simultaneous read/write across pointer wrap
        dv = 8'h40;
        for (int i = 0; i < 8; i++) begin step(1, 0, dv, 0); dv++; end
        for (int i = 0; i < 20; i++) begin step(1, 1, dv, 0); dv++; end
        chk("t3_count", cnt[0], 8);
        for (int i = 0; i < 8; i++) step(0, 1, 8'h00, 0);

        // 4: threshold sweep 0..16..0
        af_th = 5'd12; ae_th = 5'd3;
        step(0, 0, 8'h00, 0);
        for (int i = 0; i < 17; i++) step(1, 0, DSIZE'(8'h80 + i), 0);
        for (int i = 0; i < 17; i++) step(0, 1, 8'h00, 0);

        // 5: underflow with set/clear in the same cycle
        step(0, 1, 8'h00, 0);
        step(0, 1, 8'h00, 1);
        chk("t5_udf_set_wins", udf[0], 1);
        step(0, 0, 8'h00, 1);
        chk("t5_udf_clr", udf[0], 0);
        step(0, 0, 8'h00, 0);

        // Random traffic with varying bias and thresholds
        for (int seg = 0; seg < 20; seg++) begin
            int pw, pr;
            pw = $urandom_range(10, 90);
            pr = $urandom_range(10, 90);
            af_th = ASIZE'(0) + 5'($urandom_range(0, 20));
            ae_th = 5'($urandom_range(0, 20));
            for (int i = 0; i < 80; i++)
                step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr,
                     DSIZE'($urandom), $urandom_range(0, 29) == 0);
        end
        for (int i = 0; i < 17; i++) step(0, 1, 8'h00, 0);
        af_th = 5'd14; ae_th = 5'd2;
        step(0, 0, 8'h00, 1);

        // 6: FWFT visibility, then reset mid-stream with 5 words queued
        step(1, 0, 8'h5A, 0);
        chk("t6_fwft_rempty", rempty[1], 0);
        chk("t6_fwft_rdata", rdata[1], 8'h5A);
        for (int i = 0; i < 4; i++) step(1, 0, DSIZE'(8'hC0 + i), 0);
        step(0, 0, 8'h00, 0);
        chk("t6_count_pre", cnt[1], 5);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_count", cnt[1], 0);
        chk("t6_rst_rempty", rempty[1], 1);
        chk("t6_rst_rdata_fwft", rdata[1], 0);
        chk("t6_rst_rdata_std", rdata[0], 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        step(1, 0, 8'h77, 0);
        step(0, 1, 8'h00, 0);
        step(0, 0, 8'h00, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_fifo_prog.md
Name: sync_fifo_prog

Overview:
- Single-clock, parametrised FIFO and next generation of the lab async_fifo family, for intra-domain buffering where no CDC is needed.
- Adds over the existing FIFO:
  - runtime-programmable almost_full / almost_empty thresholds
  - occupancy count output
  - selectable first-word-fall-through (FWFT) or standard read mode
  - sticky overflow/underflow error flags with clear

Parameters:
- DSIZE, 8, data word width in bits.
- ASIZE, 4, address width; DEPTH = 2**ASIZE entries.
- FWFT, 0, 0 = standard read (registered rdata, 1-cycle latency); 1 = head word visible on rdata whenever not empty.

Ports:
- clk  in  1  sole clock, all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- wdata  in  DSIZE  write data.
- winc  in  1  write request.
- rinc  in  1  read request.
- af_thresh  in  ASIZE+1  almost_full threshold.
- ae_thresh  in  ASIZE+1  almost_empty threshold.
- clr_err  in  1  one-cycle pulse, clears overflow/underflow.
- rdata  out  DSIZE  read data.
- wfull  out  1  FIFO holds DEPTH words.
- rempty  out  1  FIFO holds 0 words.
- almost_full  out  1  count >= af_thresh.
- almost_empty  out  1  count <= ae_thresh.
- count  out  ASIZE+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.

Behaviour:
Reset (async assert, sync release):
- wptr = rptr = 0, count = 0.
- rempty = 1, wfull = 0, almost_full = 0, almost_empty = 1.
- overflow = underflow = 0, rdata = 0.
- Memory array is not reset.

Pointers and occupancy:
- wptr and rptr are ASIZE+1 bits; the MSB distinguishes wrap.
- Memory is indexed by the low ASIZE bits.
- Pointers wrap naturally from 2*DEPTH-1 to 0.

Accept rules:
- Write accepted iff winc && !wfull. Read accepted iff rinc && !rempty.
- Both evaluated against the current, registered flags.
- No write-through on full; no read-through on empty.

Count update:
- +1 on write only, -1 on read only.
- Unchanged on simultaneous accepted read and write, or on neither.

Flags:
- All flags are registered from next-count, so each flag reflects the count after the same edge that changes count (0-cycle lag relative to count).
- wfull = (count_next == DEPTH); rempty = (count_next == 0).
- almost_full = (count_next >= af_thresh); almost_empty = (count_next <= ae_thresh).
- Threshold values above DEPTH are legal: af never asserts, ae is always asserted.
- af_thresh = 0 forces almost_full = 1 from the first edge after reset.
- Thresholds may change at any time; the flags follow on the next edge.

Read data:
- FWFT=0: on an accepted read, rdata <= mem[rptr] at that edge (valid the cycle after rinc). rdata holds otherwise, including when the FIFO is empty.
- FWFT=1: rdata = mem[rptr] combinationally. Valid whenever rempty = 0. A word written into an empty FIFO is visible the cycle after the write edge, together with rempty falling. When empty, rdata is don't-care.

Error flags:
- overflow sets on winc && wfull; underflow sets on rinc && rempty.
- clr_err clears both flags. If set and clear occur in the same cycle, set wins.
- A rejected operation never alters pointers, memory, or count.

Other rules:
- Reset asserted mid-operation: all state returns to reset values immediately. In-flight data is discarded.
- Simultaneous read and write at full: only the read is accepted; count goes from DEPTH to DEPTH-1.
- Simultaneous read and write at empty: only the write is accepted; count goes from 0 to 1.

Decomposition:
- Shared package fifo_pkg:
  - default DSIZE/ASIZE localparams
  - fifo_ptr_t style typedef helper for ASIZE+1-bit pointers/counts, parametrised via the module
  - status struct {wfull, rempty, almost_full, almost_empty} for the bench monitor
- One sub-module: fifo_mem_dp, a DEPTH x DSIZE flop array with synchronous write port and asynchronous read port, reusable by the async_fifo successor.
- Pointer, flag and error logic stays in sync_fifo_prog.

Test Plan (DSIZE=8, ASIZE=4):
1. Reset, then write 0x11,0x22,0x33 with FWFT=0, then read 3 -> rdata 0x11,0x22,0x33 each one cycle after its rinc; count 3->0; rempty returns to 1 on the last read edge.
2. Write 16 words 0x00..0x0F, plus a 17th write of 0xAA -> wfull=1 at count=16; overflow=1; 0xAA is never read back; reading 16 words returns 0x00..0x0F in order.
3. Fill to 8, then drive winc and rinc together for 20 cycles with incrementing data -> count stays 8; output order is preserved across pointer wrap; no flag toggles.
4. af_thresh=12, ae_thresh=3, stepping count 0..16..0 -> almost_empty=1 for count<=3; almost_full=1 for count>=12; each flag changes on the same edge as count.
5. rinc on empty, then clr_err pulsed in the same cycle as a second empty rinc -> underflow stays 1; a later clr_err alone -> underflow=0.
6. FWFT=1: write 0x5A to empty -> the next cycle shows rempty=0 and rdata=0x5A with no rinc. Then assert rst_n=0 mid-stream with 5 words queued -> count=0, rempty=1 immediately, rdata=0.
